tpu_deskew_collect: RTL and testbench
=====================================

TPU_DESKEW_COLLECT -- requirements
Module: tpu_deskew_collect

Interface
REQ-001 SHALL have parameter N_COLS, default 4, number of systolic-array output columns.
REQ-002 SHALL have parameter DATA_W, default 18, width of one column result.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, row buffer depth; power of two, at least N_COLS+2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port col_valid  input  N_COLS  per-column result valid; bit c is skewed c cycles after bit 0.
REQ-007 SHALL have port col_data  input  N_COLS*DATA_W  per-column result; column c occupies bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-009 SHALL have port stall_out  output  1  back-pressure to the array launcher.
REQ-010 SHALL have port row_valid  output  1  aligned row available.
REQ-011 SHALL have port row_ready  input  1  consumer accepts the row.
REQ-012 SHALL have port row_data  output  N_COLS*DATA_W  aligned row, same column packing as col_data.
REQ-013 SHALL have port ovf  output  1  sticky: a row was dropped on a full buffer.
REQ-014 SHALL have port misalign  output  1  sticky: delayed valids disagreed within one row.

Function
REQ-015 Lane c SHALL delay col_valid[c] and its data by N_COLS-1-c register stages; lane N_COLS-1 SHALL use zero stages.
REQ-016 The aligned row SHALL be valid in a cycle when all delayed lane valids are 1.
REQ-017 A cycle where some, but not all, delayed lane valids are 1 SHALL set misalign and SHALL discard the partial row.
REQ-018 An aligned row SHALL be written to the FIFO on that cycle's edge when count < FIFO_DEPTH, or when count = FIFO_DEPTH and a pop occurs in the same cycle.
REQ-019 An aligned row arriving at a full FIFO with no same-cycle pop SHALL be dropped, SHALL set ovf, and SHALL leave the FIFO contents unchanged.
REQ-020 row_valid SHALL equal (count != 0).
REQ-021 row_data SHALL present the oldest stored row.
REQ-022 A pop SHALL occur when row_valid and row_ready are both 1.
REQ-023 Latency: column 0 presented in cycle 0 SHALL appear with row_valid=1 in cycle N_COLS when the FIFO was empty.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 count SHALL range 0..FIFO_DEPTH inclusive.
REQ-027 stall_out SHALL equal (count >= FIFO_DEPTH - N_COLS), so in-flight rows fit without loss when the launcher obeys it.
REQ-028 clr_err=1 SHALL clear ovf and misalign on the next edge.
REQ-029 A set event coinciding with clr_err SHALL win, leaving the flag at 1.
REQ-030 row_data when row_valid=0 SHALL be don't-care.

Reset
REQ-031 rst_n=0 SHALL immediately clear all lane delay valids, FIFO pointers, count, ovf and misalign.
REQ-032 During reset, outputs SHALL be row_valid=0, stall_out=0, ovf=0, misalign=0.
REQ-033 Data registers need not be reset.
REQ-034 Reset asserted mid-row SHALL discard all in-flight and buffered rows.
REQ-035 The first row after deassertion SHALL be one whose column 0 is presented no earlier than the first clock edge after deassertion.

Configuration
REQ-036 Macro DESKEW_DROPCNT_EN defined: the block SHALL add output drop_cnt, 16 bits, counting dropped rows, saturating at 0xFFFF, reset to 0, and cleared by clr_err.
REQ-037 Macro DESKEW_DROPCNT_EN undefined: drop_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (N_COLS=4, DATA_W=18, FIFO_DEPTH=8)
REQ-038 One skewed row, columns 0x11,0x22,0x33,0x44 presented in cycles 0..3, row_ready=1 -> row_valid=1 in cycle 4 only, with row_data={0x44,0x33,0x22,0x11}.
REQ-039 Back-to-back skewed rows every cycle for 20 rows, row_ready=1 -> 20 rows out, in order, on consecutive cycles; ovf=0.
REQ-040 row_ready=0, rows sent while obeying stall_out -> stall_out rises at count=4; no drops; draining yields all rows in order.
REQ-041 row_ready=0, stall_out ignored, 10 rows -> 8 stored, ovf=1, drop_cnt=2 when DESKEW_DROPCNT_EN is defined.
REQ-042 col_valid[2] withheld for one row -> misalign=1, no row output; clr_err pulse -> misalign=0 the next cycle.
REQ-043 rst_n pulsed low with 3 rows buffered and 2 in flight -> row_valid=0 immediately; no stale row appears afterward.

Source files
------------

// File: rtl/tpu_deskew_collect.sv
`default_nettype none
// ============================================================================
// Module   : tpu_deskew_collect
// Brief    : Re-aligns skewed systolic-array column results into whole rows.
//            Column c arrives c cycles after column 0. Each lane is delayed
//            so that all columns of a row line up. Complete rows are then
//            queued in a small FIFO with back-pressure. Sticky flags report
//            dropped rows (ovf) and torn rows (misalign).
// Options  : `define DESKEW_DROPCNT_EN adds a saturating 16-bit drop_cnt
//            output that counts rows dropped on a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_deskew_collect #(
    parameter int N_COLS     = 4,
    parameter int DATA_W     = 18,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_COLS-1:0]        col_valid,
    input  logic [N_COLS*DATA_W-1:0] col_data,
    input  logic                     clr_err,
    output logic                     stall_out,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [N_COLS*DATA_W-1:0] row_data,
    output logic                     ovf,
    output logic                     misalign
`ifdef DESKEW_DROPCNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam int              c_CW       = c_AW + 1;
    localparam int              c_RW       = N_COLS * DATA_W;
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_STALL_TH = c_CW'(FIFO_DEPTH - N_COLS);

    // Lane outputs after deskew delay
    logic [N_COLS-1:0] w_dly_valid;
    logic [c_RW-1:0]   w_dly_data;

    // ------------------------------------------------------------------
    // Deskew lanes: lane c is delayed by N_COLS-1-c stages so that every
    // column of a row reaches the collector in the same cycle as the
    // last (undelayed) column.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < N_COLS; c++) begin : g_lane
        localparam int c_DEPTH = N_COLS - 1 - c;

        if (c_DEPTH == 0) begin : g_pass
            assign w_dly_valid[c]                  = col_valid[c];
            assign w_dly_data[c*DATA_W +: DATA_W]  = col_data[c*DATA_W +: DATA_W];
        end else begin : g_delay
            logic [c_DEPTH-1:0]        r_v;
            logic [c_DEPTH*DATA_W-1:0] r_d;

            // Valid shift chain; cleared by reset so no stale row survives it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= '0;
                end else begin
                    r_v <= (r_v << 1) | c_DEPTH'(col_valid[c]);
                end
            end

            // Data shift chain, qualified only by the valid chain
            always_ff @(posedge clk) begin
                r_d <= (r_d << DATA_W) | (c_DEPTH*DATA_W)'(col_data[c*DATA_W +: DATA_W]);
            end

            assign w_dly_valid[c]                 = r_v[c_DEPTH-1];
            assign w_dly_data[c*DATA_W +: DATA_W] = r_d[(c_DEPTH-1)*DATA_W +: DATA_W];
        end
    end

    // ------------------------------------------------------------------
    // Row FIFO
    // ------------------------------------------------------------------
    logic [c_RW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic w_all;
    logic w_partial;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Row assembly and FIFO handshake decode
    always_comb begin
        w_all     = &w_dly_valid;
        w_partial = (|w_dly_valid) & ~w_all;
        w_pop     = row_valid & row_ready;
        // A full FIFO still accepts a row when the head leaves this cycle
        w_push    = w_all & ((r_count != c_FULL) | w_pop);
        w_drop    = w_all & ~w_push;
    end

    assign row_valid = (r_count != '0);
    assign stall_out = (r_count >= c_STALL_TH);
    assign row_data  = r_mem[r_rd_ptr];

    // Row storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dly_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new event takes priority over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            misalign <= 1'b0;
        end else begin
            if (w_drop) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (w_partial) begin
                misalign <= 1'b1;
            end else if (clr_err) begin
                misalign <= 1'b0;
            end
        end
    end

`ifdef DESKEW_DROPCNT_EN
    // Saturating drop counter; a drop in the clearing cycle counts as the first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (clr_err) begin
            drop_cnt <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tpu_deskew_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_deskew_collect
// Brief    : Self-checking bench for tpu_deskew_collect (N_COLS=4,
//            DATA_W=18, FIFO_DEPTH=8). A directed vector table covers single
//            rows and misalign/clear behaviour. Hand sequences with a small
//            row-queue model cover streaming, back-pressure, overflow and
//            reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_deskew_collect;

    localparam int N  = 4;
    localparam int W  = 18;
    localparam int D  = 8;
    localparam int RW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  col_valid;
    logic [RW-1:0] col_data;
    logic          clr_err;
    logic          stall_out;
    logic          row_valid;
    logic          row_ready;
    logic [RW-1:0] row_data;
    logic          ovf;
    logic          misalign;
`ifdef DESKEW_DROPCNT_EN
    logic [15:0]   drop_cnt;
`endif

    tpu_deskew_collect #(
        .N_COLS     (N),
        .DATA_W     (W),
        .FIFO_DEPTH (D)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_valid (col_valid),
        .col_data  (col_data),
        .clr_err   (clr_err),
        .stall_out (stall_out),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .ovf       (ovf),
        .misalign  (misalign)
`ifdef DESKEW_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Row model state
    int   exp_q[$];
    int   launch_t[$];
    int   row_id[$];
    int   cyc;
    int   next_id;
    logic exp_ovf;
    int   exp_drops;

    typedef struct {
        logic [N-1:0]  cv;
        logic [RW-1:0] cd;
        logic          rr;
        logic          clr;
        logic          e_rv;
        logic [RW-1:0] e_data;
        logic          e_stall;
        logic          e_ovf;
        logic          e_mis;
    } vec_t;

    vec_t tv [20];

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] lane(input int c, input logic [W-1:0] v);
        logic [RW-1:0] r;
        r = '0;
        r[c*W +: W] = v;
        return r;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] cv, input logic [RW-1:0] cd,
                                input logic rr, input logic clr, input logic e_rv,
                                input logic [RW-1:0] e_data, input logic e_stall,
                                input logic e_ovf, input logic e_mis);
        vec_t v;
        v.cv = cv; v.cd = cd; v.rr = rr; v.clr = clr; v.e_rv = e_rv;
        v.e_data = e_data; v.e_stall = e_stall; v.e_ovf = e_ovf; v.e_mis = e_mis;
        return v;
    endfunction

    function automatic logic [W-1:0] dval(input int id, input int c);
        return W'(id * 16 + c + 1);
    endfunction

    function automatic logic [RW-1:0] pack_row(input int id);
        logic [RW-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) r[c*W +: W] = dval(id, c);
        return r;
    endfunction

    // Present the columns of every launched row that is due this cycle
    task automatic drive_cols();
        logic [N-1:0]  cv;
        logic [RW-1:0] cd;
        cv = '0;
        cd = '0;
        foreach (launch_t[i]) begin
            int d;
            d = cyc - launch_t[i];
            if (d >= 0 && d < N) begin
                cv[d]       = 1'b1;
                cd[d*W +: W] = dval(row_id[i], d);
            end
        end
        col_valid = cv;
        col_data  = cd;
    endtask

    // Run n cycles: optionally launch a new skewed row each cycle, check
    // outputs mid-cycle against the queue model, then advance the model.
    task automatic run(input int n, input int launch_until, input bit obey_stall,
                       input logic rdy, input string tag);
        for (int k = 0; k < n; k++) begin
            bit pop;
            int land;
            @(posedge clk);
            #1;
            if (cyc < launch_until && (!obey_stall || !stall_out)) begin
                launch_t.push_back(cyc);
                row_id.push_back(next_id);
                next_id++;
            end
            row_ready = rdy;
            drive_cols();
            @(negedge clk);
            check($sformatf("%s c%0d row_valid", tag, cyc), RW'(row_valid), RW'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                check($sformatf("%s c%0d row_data", tag, cyc), row_data, pack_row(exp_q[0]));
            check($sformatf("%s c%0d stall_out", tag, cyc), RW'(stall_out), RW'(exp_q.size() >= D - N));
            check($sformatf("%s c%0d ovf", tag, cyc), RW'(ovf), RW'(exp_ovf));
            check($sformatf("%s c%0d misalign", tag, cyc), RW'(misalign), '0);
            pop  = (exp_q.size() != 0) && rdy;
            land = -1;
            foreach (launch_t[i]) if (launch_t[i] + N - 1 == cyc) land = row_id[i];
            if (pop) void'(exp_q.pop_front());
            if (land >= 0) begin
                if (exp_q.size() < D) exp_q.push_back(land);
                else begin
                    exp_ovf = 1'b1;
                    exp_drops++;
                end
            end
            cyc++;
        end
    endtask

    // Assert reset between edges, check outputs clear at once, then release
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        col_valid = '0;
        col_data  = '0;
        row_ready = 1'b0;
        clr_err   = 1'b0;
        #1;
        check({tag, " rst row_valid"}, RW'(row_valid), '0);
        check({tag, " rst stall_out"}, RW'(stall_out), '0);
        check({tag, " rst ovf"},       RW'(ovf),       '0);
        check({tag, " rst misalign"},  RW'(misalign),  '0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        launch_t.delete();
        row_id.delete();
        cyc       = 0;
        next_id   = 0;
        exp_ovf   = 1'b0;
        exp_drops = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        col_valid = '0;
        col_data  = '0;
        row_ready = 1'b0;
        clr_err   = 1'b0;
        cyc       = 0;
        next_id   = 0;
        exp_ovf   = 1'b0;
        exp_drops = 0;

        // Single row, misalign with clear, misalign coinciding with clear
        tv[0]  = mk(4'b0001, lane(0, 18'h11), 1, 0, 0, '0, 0, 0, 0);
        tv[1]  = mk(4'b0010, lane(1, 18'h22), 1, 0, 0, '0, 0, 0, 0);
        tv[2]  = mk(4'b0100, lane(2, 18'h33), 1, 0, 0, '0, 0, 0, 0);
        tv[3]  = mk(4'b1000, lane(3, 18'h44), 1, 0, 0, '0, 0, 0, 0);
        tv[4]  = mk(4'b0000, '0, 1, 0, 1, {18'h44, 18'h33, 18'h22, 18'h11}, 0, 0, 0);
        tv[5]  = mk(4'b0000, '0, 1, 0, 0, '0, 0, 0, 0);
        tv[6]  = mk(4'b0001, lane(0, 18'h55), 1, 0, 0, '0, 0, 0, 0);
        tv[7]  = mk(4'b0010, lane(1, 18'h66), 1, 0, 0, '0, 0, 0, 0);
        tv[8]  = mk(4'b0000, '0, 1, 0, 0, '0, 0, 0, 0);
        tv[9]  = mk(4'b1000, lane(3, 18'h88), 1, 0, 0, '0, 0, 0, 0);
        tv[10] = mk(4'b0000, '0, 1, 0, 0, '0, 0, 0, 1);
        tv[11] = mk(4'b0000, '0, 1, 1, 0, '0, 0, 0, 1);
        tv[12] = mk(4'b0000, '0, 1, 0, 0, '0, 0, 0, 0);
        tv[13] = mk(4'b0001, lane(0, 18'h99), 1, 0, 0, '0, 0, 0, 0);
        tv[14] = mk(4'b0010, lane(1, 18'hAA), 1, 0, 0, '0, 0, 0, 0);
        tv[15] = mk(4'b0100, lane(2, 18'hBB), 1, 0, 0, '0, 0, 0, 0);
        tv[16] = mk(4'b0000, '0, 1, 1, 0, '0, 0, 0, 0);
        tv[17] = mk(4'b0000, '0, 1, 0, 0, '0, 0, 0, 1);
        tv[18] = mk(4'b0000, '0, 1, 1, 0, '0, 0, 0, 1);
        tv[19] = mk(4'b0000, '0, 1, 0, 0, '0, 0, 0, 0);

        // Power-on reset
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("por row_valid", RW'(row_valid), '0);
        check("por stall_out", RW'(stall_out), '0);
        check("por ovf",       RW'(ovf),       '0);
        check("por misalign",  RW'(misalign),  '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            col_valid = tv[i].cv;
            col_data  = tv[i].cd;
            row_ready = tv[i].rr;
            clr_err   = tv[i].clr;
            @(negedge clk);
            check($sformatf("vec%0d row_valid", i), RW'(row_valid), RW'(tv[i].e_rv));
            check($sformatf("vec%0d stall_out", i), RW'(stall_out), RW'(tv[i].e_stall));
            check($sformatf("vec%0d ovf", i),       RW'(ovf),       RW'(tv[i].e_ovf));
            check($sformatf("vec%0d misalign", i),  RW'(misalign),  RW'(tv[i].e_mis));
            if (tv[i].e_rv) check($sformatf("vec%0d row_data", i), row_data, tv[i].e_data);
        end

        // 20 back-to-back rows with the consumer always ready
        do_reset("B");
        run(28, 20, 1'b1 && 1'b0, 1'b1, "stream");

        // Consumer stalled, launcher obeys stall_out, then drain
        do_reset("C");
        run(20, 30, 1'b1, 1'b0, "obey");
        run(12, 0, 1'b0, 1'b1, "obey_drain");

        // Consumer stalled, stall_out ignored: 10 rows into 8 slots
        do_reset("D");
        run(14, 10, 1'b0, 1'b0, "ovf_fill");
`ifdef DESKEW_DROPCNT_EN
        check("drop_cnt after overflow", RW'(drop_cnt), RW'(exp_drops));
`endif
        run(12, 0, 1'b0, 1'b1, "ovf_drain");
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(negedge clk);
        check("ovf held during clr cycle", RW'(ovf), RW'(exp_ovf));
        @(posedge clk);
        #1 clr_err = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        check("ovf after clr", RW'(ovf), RW'(exp_ovf));
`ifdef DESKEW_DROPCNT_EN
        check("drop_cnt after clr", RW'(drop_cnt), '0);
`endif

        // Reset with 3 rows buffered and 2 in flight; nothing stale afterward
        do_reset("E0");
        run(6, 5, 1'b0, 1'b0, "pre_rst");
        do_reset("E");
        run(12, 0, 1'b0, 1'b1, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
